// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the memory command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RSP      = 3'd4
    } mem_state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Single-command memory controller: one-cycle writes, registered-memory reads (burst reads when MEM_CTRL_BURST_EN is defined).
// Latency: write strobe 1 edge after acceptance; rsp_valid on the 3rd edge counting the accepting edge, +3 edges per further beat.
// Backpressure: one command in flight; cmd_ready only in IDLE, each response beat is held stable until rsp_ready is sampled.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_valid,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    mem_state_t            state_q;
    mem_state_t            state_d;
    logic                  out_of_reset_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  cmd_accept;
    logic                  beat_taken;
    logic                  last_beat;

    assign cmd_ready  = (state_q == IDLE) && out_of_reset_q;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign beat_taken = (state_q == RSP) && rsp_ready;

`ifdef MEM_CTRL_BURST_EN
    logic [3:0] beat_q;

    assign last_beat = (beat_q == 4'd0);

    // Remaining-beat counter: loads cmd_len on acceptance, counts down as each non-final beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= 4'd0;
        end else if (cmd_accept) begin
            beat_q <= cmd_len;
        end else if (beat_taken && !last_beat) begin
            beat_q <= beat_q - 4'd1;
        end
    end
`else
    // Single-beat build: the length field is accepted on the port but has no effect.
    logic unused_cmd_len;
    assign unused_cmd_len = ^cmd_len;
    assign last_beat      = 1'b1;
`endif

    // Hold cmd_ready low until the first clock edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: the direction captured at acceptance is carried by the WR vs RD_ISSUE branch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmd_accept) state_d = cmd_write ? WR : RD_ISSUE;
            WR:       state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RSP;
            RSP:      if (rsp_ready) state_d = last_beat ? IDLE : RD_ISSUE;
            default:  state_d = IDLE;
        endcase
    end

    // Command capture, wrapping burst address step, and response data capture from the registered memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (cmd_accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end else if (beat_taken && !last_beat) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == RD_WAIT) begin
                rsp_data_q <= mem_rd_data;
            end
        end
    end

    // Strobes decode straight from the state so an asynchronous reset clears them at once.
    assign mem_valid   = (state_q == WR);
    assign mem_wr_en   = (state_q == WR);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_ready   = (state_q == RD_ISSUE);
    assign mem_rd_en   = (state_q == RD_ISSUE);
    assign mem_rd_addr = addr_q;
    assign rsp_valid   = (state_q == RSP);
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != IDLE);

endmodule
